// File: rtl/branch_cond_unit.sv
// branch_cond_unit: holds the ALU status {V,N,Z} and resolves one conditional
// branch at a time. Each accepted request produces taken, illegal and next_pc,
// and done pulses high for one cycle when they are valid.
//
// Handshake: br_req is a single-cycle valid with an implicit ready of !busy.
// A request is accepted on a rising edge where br_req=1 and the FSM is in IDLE.
// Requests made while busy are dropped, not queued. The result is valid in the
// cycle where done=1. taken, illegal and next_pc keep that value until the next
// evaluation.
module branch_cond_unit #(
  parameter int PC_W  = 9,
  parameter int IMM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_s,
  input  logic [2:0]       status_in,
  input  logic             br_req,
  input  logic [2:0]       cond,
  input  logic [IMM_W-1:0] imm,
  input  logic [PC_W-1:0]  pc_in,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic             illegal,
  output logic [PC_W-1:0]  next_pc,
  output logic [2:0]       status_q,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] C_B   = 3'b000;
  localparam logic [2:0] C_BEQ = 3'b001;
  localparam logic [2:0] C_BNE = 3'b010;
  localparam logic [2:0] C_BLT = 3'b011;
  localparam logic [2:0] C_BLE = 3'b100;

  state_t           state, state_nx;
  logic [2:0]       cond_q;
  logic [IMM_W-1:0] imm_q;
  logic [PC_W-1:0]  pc_q;
  logic             flag_z, flag_n, flag_v;
  logic             eval_taken, eval_illegal;
  logic [PC_W-1:0]  pc_seq, pc_target;

  assign flag_z = status_q[0];
  assign flag_n = status_q[1];
  assign flag_v = status_q[2];

  // The status register runs independently of the FSM. A load on the accept
  // edge is therefore already visible during EVAL, and a load on the EVAL edge
  // arrives too late for the branch being evaluated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       status_q <= 3'b000;
    else if (load_s) status_q <= status_in;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: accept only in IDLE, then step through EVAL and DONE
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (br_req) state_nx = ST_EVAL;
      ST_EVAL: state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy      = (state == ST_EVAL) || (state == ST_DONE);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

  // Capture the request operands when it is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_q <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
    end else if (state == ST_IDLE && br_req) begin
      cond_q <= cond;
      imm_q  <= imm;
      pc_q   <= pc_in;
    end
  end

  // Evaluate the condition against the current status register. Reserved codes
  // are flagged as illegal and fall through as not taken.
  always_comb begin
    eval_taken   = 1'b0;
    eval_illegal = 1'b0;
    case (cond_q)
      C_B:     eval_taken = 1'b1;
      C_BEQ:   eval_taken = flag_z;
      C_BNE:   eval_taken = !flag_z;
      C_BLT:   eval_taken = flag_n ^ flag_v;
      C_BLE:   eval_taken = (flag_n ^ flag_v) | flag_z;
      default: eval_illegal = 1'b1;
    endcase
  end

  // PC arithmetic wraps modulo 2**PC_W. The signed size cast sign-extends the
  // offset.
  assign pc_seq    = pc_q + PC_W'(1);
  assign pc_target = pc_seq + PC_W'($signed(imm_q));

  // Register the result in EVAL and hold it until the next evaluation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken   <= 1'b0;
      illegal <= 1'b0;
      next_pc <= '0;
    end else if (state == ST_EVAL) begin
      taken   <= eval_taken;
      illegal <= eval_illegal;
      next_pc <= eval_taken ? pc_target : pc_seq;
    end
  end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Testbench for branch_cond_unit. It runs a table of directed vectors,
// randomized branches checked against a reference model, and hand-written
// sequences for reset during evaluation, load ordering, and requests made
// while the unit is busy.
module tb_branch_cond_unit;

  localparam int PC_W  = 9;
  localparam int IMM_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_s;
  logic [2:0]       status_in;
  logic             br_req;
  logic [2:0]       cond;
  logic [IMM_W-1:0] imm;
  logic [PC_W-1:0]  pc_in;
  logic             busy, done, taken, illegal;
  logic [PC_W-1:0]  next_pc;
  logic [2:0]       status_q;
  logic [1:0]       state_dbg;

  int n_vec  = 0;
  int n_fail = 0;
  logic [2:0] m_status;

  branch_cond_unit #(.PC_W(PC_W), .IMM_W(IMM_W)) dut (
    .clk(clk), .reset(reset), .load_s(load_s), .status_in(status_in),
    .br_req(br_req), .cond(cond), .imm(imm), .pc_in(pc_in),
    .busy(busy), .done(done), .taken(taken), .illegal(illegal),
    .next_pc(next_pc), .status_q(status_q), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       st;
    logic [2:0]       cnd;
    logic [IMM_W-1:0] off;
    logic [PC_W-1:0]  pc;
    logic             e_taken;
    logic             e_illegal;
    logic [PC_W-1:0]  e_npc;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model, computed directly from the branch rules using integer arithmetic
  task automatic model(input logic [2:0] st, input logic [2:0] cnd, input logic [IMM_W-1:0] off,
                       input logic [PC_W-1:0] pc, output logic tk, output logic il,
                       output logic [PC_W-1:0] npc);
    bit z, n, v;
    int tgt, offs;
    z = st[0]; n = st[1]; v = st[2];
    il = 0;
    case (cnd)
      3'd0: tk = 1;
      3'd1: tk = z;
      3'd2: tk = !z;
      3'd3: tk = (n != v);
      3'd4: tk = (n != v) || z;
      default: begin tk = 0; il = 1; end
    endcase
    offs = (int'(off) >= 128) ? int'(off) - 256 : int'(off);
    tgt  = int'(pc) + 1 + (tk ? offs : 0);
    tgt  = ((tgt % 512) + 512) % 512;
    npc  = PC_W'(tgt);
  endtask

  // Drive one branch, optionally loading status on the accept edge, and check
  // latency and result
  task automatic do_branch(input string name, input logic ld, input logic [2:0] st,
                           input logic [2:0] cnd, input logic [IMM_W-1:0] off,
                           input logic [PC_W-1:0] pc, input logic e_tk, input logic e_il,
                           input logic [PC_W-1:0] e_npc);
    int lat;
    bit found;
    @(posedge clk); #1;
    br_req = 1; cond = cnd; imm = off; pc_in = pc; load_s = ld; status_in = st;
    @(posedge clk); #1;
    br_req = 0; load_s = 0;
    if (ld) m_status = st;
    chk({name, " busy_after_accept"}, {31'd0, busy}, 32'd1);
    found = 0; lat = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) found = 1;
    end
    chk({name, " done_latency"}, found ? lat : 99, 32'd1);
    chk({name, " taken"}, {31'd0, taken}, {31'd0, e_tk});
    chk({name, " illegal"}, {31'd0, illegal}, {31'd0, e_il});
    chk({name, " next_pc"}, {23'd0, next_pc}, {23'd0, e_npc});
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    logic tk, il;
    logic [PC_W-1:0] npc;
    logic [2:0] rs, rc;
    logic [IMM_W-1:0] ro;
    logic [PC_W-1:0] rp;
    logic rl;
    int cnt;

    // Directed vectors: status, cond, imm, pc, expected taken, illegal, next_pc
    vecs[0]  = '{3'b001, 3'b001, 8'h05, 9'd10,  1'b1, 1'b0, 9'd16};
    vecs[1]  = '{3'b001, 3'b010, 8'h05, 9'd10,  1'b0, 1'b0, 9'd11};
    vecs[2]  = '{3'b010, 3'b011, 8'hFE, 9'd3,   1'b1, 1'b0, 9'd2};
    vecs[3]  = '{3'b110, 3'b011, 8'hFE, 9'd3,   1'b0, 1'b0, 9'd4};
    vecs[4]  = '{3'b111, 3'b100, 8'hFE, 9'd3,   1'b1, 1'b0, 9'd2};
    vecs[5]  = '{3'b110, 3'b100, 8'h10, 9'd20,  1'b0, 1'b0, 9'd21};
    vecs[6]  = '{3'b000, 3'b000, 8'h00, 9'h1FF, 1'b1, 1'b0, 9'd0};
    vecs[7]  = '{3'b000, 3'b000, 8'h80, 9'd0,   1'b1, 1'b0, 9'h181};
    vecs[8]  = '{3'b000, 3'b001, 8'h05, 9'h1FF, 1'b0, 1'b0, 9'd0};
    vecs[9]  = '{3'b001, 3'b110, 8'h05, 9'd40,  1'b0, 1'b1, 9'd41};
    vecs[10] = '{3'b000, 3'b101, 8'h7F, 9'd7,   1'b0, 1'b1, 9'd8};
    vecs[11] = '{3'b100, 3'b011, 8'h7F, 9'h1F0, 1'b1, 1'b0, 9'h070};

    // Reset
    reset = 1; load_s = 0; status_in = 0; br_req = 0; cond = 0; imm = 0; pc_in = 0;
    m_status = 3'b000;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset status_q", {29'd0, status_q}, 32'd0);
    chk("reset next_pc", {23'd0, next_pc}, 32'd0);
    chk("reset taken", {31'd0, taken}, 32'd0);

    // Table-driven vectors, with the status loaded on the accept edge
    for (int i = 0; i < 12; i++) begin
      do_branch($sformatf("vec%0d", i), 1'b1, vecs[i].st, vecs[i].cnd, vecs[i].off,
                vecs[i].pc, vecs[i].e_taken, vecs[i].e_illegal, vecs[i].e_npc);
      chk($sformatf("vec%0d status_q", i), {29'd0, status_q}, {29'd0, vecs[i].st});
    end

    // Randomized branches against the reference model
    for (int i = 0; i < 40; i++) begin
      rl = 1'($urandom_range(0, 1));
      rs = 3'($urandom_range(0, 7));
      rc = 3'($urandom_range(0, 7));
      ro = 8'($urandom);
      rp = 9'($urandom);
      model(rl ? rs : m_status, rc, ro, rp, tk, il, npc);
      do_branch($sformatf("rnd%0d", i), rl, rs, rc, ro, rp, tk, il, npc);
    end

    // Ordering: load with the request, then a new load on the EVAL edge is not seen
    @(posedge clk); #1;
    br_req = 1; cond = 3'b001; imm = 8'h02; pc_in = 9'd100; load_s = 1; status_in = 3'b001;
    @(posedge clk); #1;
    br_req = 1; cond = 3'b000; pc_in = 9'd200; load_s = 1; status_in = 3'b000;
    @(posedge clk); #1;
    load_s = 0;
    chk("order done", {31'd0, done}, 32'd1);
    chk("order taken", {31'd0, taken}, 32'd1);
    chk("order next_pc", {23'd0, next_pc}, 32'd103);
    chk("order status_q", {29'd0, status_q}, 32'd0);
    @(posedge clk); #1;
    br_req = 0;
    count_dones(6, cnt);
    chk("busy req ignored", cnt, 32'd0);
    chk("held next_pc", {23'd0, next_pc}, 32'd103);
    m_status = 3'b000;

    // Reset asserted while EVAL is in progress
    @(posedge clk); #1;
    br_req = 1; cond = 3'b000; imm = 8'h10; pc_in = 9'd50; load_s = 1; status_in = 3'b011;
    @(posedge clk); #1;
    br_req = 0; load_s = 0;
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    reset = 1;
    #1;
    chk("mid reset busy", {31'd0, busy}, 32'd0);
    chk("mid reset done", {31'd0, done}, 32'd0);
    chk("mid reset status_q", {29'd0, status_q}, 32'd0);
    chk("mid reset next_pc", {23'd0, next_pc}, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    count_dones(6, cnt);
    chk("no done after reset", cnt, 32'd0);
    m_status = 3'b000;

    // The unit works again after reset
    do_branch("post reset", 1'b1, 3'b000, 3'b010, 8'h03, 9'd5, 1'b1, 1'b0, 9'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, expected finished)");
    $fatal(1, "timeout");
  end

endmodule
